// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared state encoding, image constants and address width for the
//           image-dump memory arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

   localparam int C_ADDR_W    = 32;
   localparam int C_IMG_BYTES = 152100;
   localparam int C_WORD_BASE = 152100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_port_mux.sv
// ============================================================================
// Module  : mem_port_mux
// Brief   : Combinational memory-port owner select between CPU and streamer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_mux
   import mem_pkg::*;
(
   input  logic                stream_own,
   input  logic [C_ADDR_W-1:0] stream_addr,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [C_ADDR_W-1:0] cpu_addr,
   input  logic [31:0]         cpu_wd,
   output logic                mem_we,
   output logic [C_ADDR_W-1:0] mem_addr,
   output logic [31:0]         mem_wd,
   output logic                cpu_stall
);

   always_comb begin
      mem_we    = cpu_req & cpu_we;
      mem_addr  = cpu_addr;
      mem_wd    = cpu_wd;
      cpu_stall = 1'b0;
      if (stream_own) begin
         // Streamer only ever reads; write data is left on the CPU value.
         mem_we    = 1'b0;
         mem_addr  = stream_addr;
         cpu_stall = cpu_req;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_stream_arbiter.sv
// ============================================================================
// Module  : mem_stream_arbiter
// Brief   : Streams an image region byte-by-byte out of a shared data memory,
//           arbitrating the port against CPU accesses with starvation bound.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stream_arbiter
   import mem_pkg::*;
#(
   parameter int IMG_BYTES  = C_IMG_BYTES,
   parameter int BASE_ADDR  = 0,
   parameter int STARVE_MAX = 4
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [C_ADDR_W-1:0] cpu_addr,
   input  logic [31:0]         cpu_wd,
   output logic [31:0]         cpu_rd,
   output logic                cpu_stall,
   input  logic                start,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                mem_we,
   output logic [C_ADDR_W-1:0] mem_addr,
   output logic [31:0]         mem_wd,
   input  logic [31:0]         mem_rd
);

   localparam logic [2:0]  STARVE_LIM = 3'(STARVE_MAX);
   localparam logic [17:0] LAST_PTR   = 18'(IMG_BYTES - 1);

   state_e      state_q, state_d;
   logic [17:0] ptr_q, ptr_d;
   logic [2:0]  starve_q, starve_d;
   logic        tx_valid_q, tx_valid_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        done_q, done_d;

   logic                grant_s;
   logic [C_ADDR_W-1:0] stream_addr;
   logic                unused_rd;

   assign unused_rd   = ^mem_rd[31:8];
   assign grant_s     = (state_q == ST_FETCH) && (!cpu_req || (starve_q == STARVE_LIM));
   assign stream_addr = 32'(BASE_ADDR) + {14'd0, ptr_q};

   mem_port_mux u_mux (
      .stream_own  (grant_s),
      .stream_addr (stream_addr),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wd      (cpu_wd),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wd      (mem_wd),
      .cpu_stall   (cpu_stall)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      starve_d   = starve_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d = ST_FETCH;
               ptr_d   = '0;
            end
         end
         ST_FETCH: begin
            if (grant_s) begin
               tx_data_d  = mem_rd[7:0];
               tx_valid_d = 1'b1;
               starve_d   = '0;
               state_d    = ST_SEND;
            end else begin
               starve_d = starve_q + 3'd1;
            end
         end
         ST_SEND: begin
            if (tx_valid_q && tx_ready) begin
               tx_valid_d = 1'b0;
               if (ptr_q == LAST_PTR) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  ptr_d   = ptr_q + 18'd1;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      // Abort overrides every transition, including the one into DONE.
      if (abort && (state_q != ST_IDLE)) begin
         state_d    = ST_IDLE;
         tx_valid_d = 1'b0;
         starve_d   = '0;
         done_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         starve_q   <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         starve_q   <= starve_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         done_q     <= done_d;
      end
   end

   assign cpu_rd   = mem_rd;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stream_arbiter.sv
// ============================================================================
// Module  : tb_mem_stream_arbiter
// Brief   : Directed bench for mem_stream_arbiter with a 16-byte memory model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stream_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wd, cpu_rd;
   logic        cpu_stall;
   logic        start, abort, busy, done;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wd, mem_rd;

   logic [7:0]  mem [0:15];
   logic [7:0]  img [0:3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_stream_arbiter #(
      .IMG_BYTES  (4),
      .BASE_ADDR  (0),
      .STARVE_MAX (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wd    (cpu_wd),
      .cpu_rd    (cpu_rd),
      .cpu_stall (cpu_stall),
      .start     (start),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wd    (mem_wd),
      .mem_rd    (mem_rd)
   );

   assign mem_rd = {24'd0, mem[mem_addr[3:0]]};

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[3:0]] <= mem_wd[7:0];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
      for (int i = 0; i < 16; i++) mem[i] = (i < 4) ? img[i] : 8'hE0 + 8'(i);
      rst_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wd = 0;
      start = 0; abort = 0; tx_ready = 0;
      #3;
      chk("rst_busy",     32'(busy), 0);
      chk("rst_tx_valid", 32'(tx_valid), 0);
      chk("rst_tx_data",  32'(tx_data), 0);
      chk("rst_done",     32'(done), 0);
      chk("rst_stall",    32'(cpu_stall), 0);

      // Idle CPU, full four-byte dump
      @(negedge clk); rst_n = 1'b1; tx_ready = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("dump_fetch_addr", mem_addr, 32'(i));
         chk("dump_fetch_we",   32'(mem_we), 0);
         chk("dump_busy",       32'(busy), 1);
         @(negedge clk);
         chk("dump_valid", 32'(tx_valid), 1);
         chk("dump_data",  32'(tx_data), 32'(img[i]));
         chk("dump_nodone", 32'(done), 0);
         @(negedge clk);
      end
      chk("dump_done_pulse", 32'(done), 1);
      @(negedge clk);
      chk("dump_done_end", 32'(done), 0);
      chk("dump_idle",     32'(busy), 0);

      // CPU holds the port: four CPU wins, then one forced stall
      cpu_req = 1'b1; cpu_addr = 32'h100; tx_ready = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("starve_cpu_wins", 32'(cpu_stall), 0);
         chk("starve_cpu_addr", mem_addr, 32'h100);
         @(negedge clk);
      end
      chk("starve_forced_stall", 32'(cpu_stall), 1);
      chk("starve_forced_addr",  mem_addr, 0);
      @(negedge clk);
      chk("starve_captured", 32'(tx_data), 32'h11);
      chk("starve_valid",    32'(tx_valid), 1);
      chk("starve_send_nostall", 32'(cpu_stall), 0);
      cpu_req = 1'b0; tx_ready = 1'b1;
      @(negedge clk);
      chk("next_fetch_addr", mem_addr, 1);
      tx_ready = 1'b0;
      @(negedge clk);

      // Backpressure in SEND for 10 cycles
      cpu_req = 1'b1; cpu_addr = 32'h55;
      for (int j = 0; j < 10; j++) begin
         #1;
         chk("bp_valid", 32'(tx_valid), 1);
         chk("bp_data",  32'(tx_data), 32'h22);
         chk("bp_addr",  mem_addr, 32'h55);
         @(negedge clk);
      end
      cpu_req = 1'b0; tx_ready = 1'b1;
      @(negedge clk);
      chk("bp_ptr_next", mem_addr, 2);
      tx_ready = 1'b0;
      @(negedge clk);
      chk("abort_pre_data", 32'(tx_data), 32'h33);

      // Abort in SEND at ptr=2, then restart from base
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("abort_idle",  32'(busy), 0);
      chk("abort_valid", 32'(tx_valid), 0);
      chk("abort_nodone", 32'(done), 0);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("restart_addr", mem_addr, 0);

      // start while busy is ignored
      start = 1'b1;
      @(negedge clk);
      chk("busy_start_data",  32'(tx_data), 32'h11);
      chk("busy_start_valid", 32'(tx_valid), 1);
      @(negedge clk); start = 1'b0;
      chk("busy_start_hold", 32'(tx_valid), 1);
      chk("busy_start_busy", 32'(busy), 1);

      // Asynchronous reset mid-FETCH with a CPU store pending
      tx_ready = 1'b1;
      @(negedge clk);
      chk("prereset_fetch", mem_addr, 1);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd10; cpu_wd = 32'hABCD;
      #1;
      chk("prereset_busy",  32'(busy), 1);
      chk("prereset_stall", 32'(cpu_stall), 0);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_busy",     32'(busy), 0);
      chk("arst_valid",    32'(tx_valid), 0);
      chk("arst_done",     32'(done), 0);
      chk("arst_stall",    32'(cpu_stall), 0);
      chk("arst_mem_we",   32'(mem_we), 1);
      chk("arst_mem_addr", mem_addr, 10);
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("post_rst_we",   32'(mem_we), 1);
      chk("post_rst_addr", mem_addr, 10);
      chk("post_rst_wd",   mem_wd, 32'hABCD);
      chk("post_rst_done", 32'(done), 0);

      // start+abort together in IDLE
      cpu_req = 1'b0; cpu_we = 1'b0; start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      chk("start_abort_idle", 32'(busy), 0);
      @(negedge clk);
      chk("start_abort_still", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_stream_arbiter.md
MEM_STREAM_ARBITER -- requirements
Module: mem_stream_arbiter

Interface
REQ-001 Parameter IMG_BYTES, 152100: number of image bytes streamed, at addresses BASE_ADDR..BASE_ADDR+IMG_BYTES-1.
REQ-002 Parameter BASE_ADDR, 0: first byte address of the image region.
REQ-003 Parameter STARVE_MAX, 4: maximum consecutive FETCH cycles the CPU may win before the streamer is forced onto the port.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  CPU data access this cycle (load or store).
REQ-007 cpu_we  in  1  CPU store strobe, qualified by cpu_req.
REQ-008 cpu_addr  in  32  CPU byte address.
REQ-009 cpu_wd  in  32  CPU write data.
REQ-010 cpu_rd  out  32  CPU read data, equal to mem_rd.
REQ-011 cpu_stall  out  1  CPU access not granted this cycle.
REQ-012 start  in  1  single-cycle pulse that starts an image dump.
REQ-013 abort  in  1  cancels a dump in progress.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse when a dump completes.
REQ-016 tx_data  out  8  streamed byte, registered.
REQ-017 tx_valid  out  1  tx_data is valid.
REQ-018 tx_ready  in  1  sink accepts the byte.
REQ-019 mem_we, mem_addr[31:0], mem_wd[31:0]  out  memory port toward the data memory.
REQ-020 mem_rd  in  32  combinational read data from the memory.

Function
REQ-021 States: IDLE, FETCH, SEND, DONE, encoded as a 2-bit enum.
- IDLE -> FETCH on start; ptr loads 0.
- start while busy is ignored.
REQ-022 Port mux, combinational:
- Streamer owns the port only in a FETCH cycle where grant_s=1; it then drives mem_we=0 and mem_addr=BASE_ADDR+ptr.
- In every other cycle the CPU owns the port: mem_we=cpu_req&cpu_we, mem_addr=cpu_addr, mem_wd=cpu_wd.
REQ-023 grant_s in FETCH = !cpu_req | (starve_cnt==STARVE_MAX).
REQ-024 cpu_stall = cpu_req & streamer owns the port; cpu_stall=0 outside FETCH.
REQ-025 starve_cnt (3 bits) behaviour:
- increments on each FETCH cycle the CPU wins;
- clears on a streamer grant;
- clears on leaving FETCH.
REQ-026 FETCH with grant_s=1: tx_data<=mem_rd[7:0], tx_valid<=1, go to SEND.
- Fetch latency is one cycle when the CPU is idle.
- Worst case is STARVE_MAX+1 cycles.
REQ-027 SEND: tx_valid and tx_data hold stable until tx_valid&tx_ready.
- On that handshake, tx_valid<=0.
- If ptr==IMG_BYTES-1, go to DONE; otherwise ptr<=ptr+1 and go to FETCH.
REQ-028 DONE lasts exactly one cycle with done=1, then returns to IDLE.
REQ-029 abort has priority over all transitions, in any non-IDLE state:
- next state IDLE, tx_valid<=0, starve_cnt<=0;
- done is not pulsed.
REQ-030 abort and start in the same cycle while in IDLE: abort wins and the state stays IDLE.
REQ-031 ptr is 18 bits, counts 0..IMG_BYTES-1 and never wraps; the address sum is zero-extended to 32 bits.
REQ-032 Pass-through: CPU stores to the image region during a dump are allowed; a byte already sent is not resent.

Reset
REQ-033 rst_n low forces, asynchronously, these values: state=IDLE, ptr=0, starve_cnt=0, tx_valid=0, tx_data=0, done=0.
REQ-034 While rst_n is low the combinational outputs follow the IDLE mux (CPU owns the port), so busy=0 and cpu_stall=0.
REQ-035 Reset asserted mid-dump drops tx_valid immediately, without a handshake, and no done pulse is produced.

Structure
REQ-036 A shared package mem_pkg holds:
- the state enum;
- the image constants IMG_BYTES=152100 and the word-region base 152100;
- the address width 32.
REQ-037 One sub-module, mem_port_mux, holds the combinational owner select of REQ-022/024; the FSM, counters and tx register stay in the top level.

Verification
REQ-038 Idle CPU, IMG_BYTES=4 with bytes 11,22,33,44 and tx_ready=1: the four bytes stream in order, each tx_valid one cycle after its FETCH cycle, then a single done pulse.
REQ-039 cpu_req=1 held through a dump: the CPU wins STARVE_MAX=4 FETCH cycles, then cpu_stall=1 for exactly one cycle and the byte is captured.
REQ-040 tx_ready=0 for 10 cycles in SEND: tx_valid stays 1, tx_data stays 0x22, ptr is unchanged, and mem_addr follows cpu_addr.
REQ-041 abort in SEND at ptr=2: the next cycle is IDLE with tx_valid=0 and no done pulse; a later start restarts from address BASE_ADDR.
REQ-042 rst_n is pulled low mid-FETCH with cpu_req=1 and cpu_we=1 toward address 10: outputs reach their reset values without waiting for a clock edge.
- After release the CPU store passes through: mem_we=1, mem_addr=10.
REQ-043 start pulsed while busy, and start+abort in IDLE: neither changes state.
